ocs_tx_arb: RTL and testbench
=============================

OCS_TX_ARB -- requirements
Module: ocs_tx_arb

Interface
REQ-001 SHALL have parameter P_TIMEOUT, default 16'd300: stall cycles allowed inside a granted frame before it is aborted.
REQ-002 SHALL have parameter P_DATA_W, default 64: AXIS data width; keep width is P_DATA_W/8.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock for the whole block.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports s0_axis_tvalid/tdata/tlast/tkeep/tuser (inputs) and s0_axis_tready (output): requester 0, time-sync frames, highest priority.
REQ-006 SHALL have ports s1_axis_* with the same set of signals as s0: requester 1, slot-control frames.
REQ-007 SHALL have ports s2_axis_* with the same set of signals as s0: requester 2, data frames.
REQ-008 SHALL have ports m_axis_tvalid/tdata/tlast/tkeep/tuser (outputs) and m_axis_tready (input): the shared TX port toward the MAC.
REQ-009 SHALL have port i_slot_guard, input, 1 bit: while high, no new grant is issued.
REQ-010 SHALL have port o_grant, output, 2 bits: the granted requester (0..2); 2'd3 when idle.
REQ-011 SHALL have port o_busy, output, 1 bit: a frame is in flight.
REQ-012 SHALL have port o_abort, output, 1 bit: one-cycle pulse when a frame is aborted on timeout.
REQ-013 SHALL have ports o_frm_cnt0/1/2, output, 16 bits each: count of completed frames per requester.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-015 In IDLE with i_slot_guard=0 and at least one sN_axis_tvalid=1, the block SHALL register a grant and move to BUSY on the next edge.
REQ-016 Grant priority SHALL be: s0 always wins; between s1 and s2, a 1-bit round-robin pointer decides.
REQ-017 The round-robin pointer SHALL reset to favour s1 and SHALL flip after each grant to s1 or s2; a grant to s0 SHALL leave it unchanged.
REQ-018 Arbitration latency SHALL be exactly one cycle: a request seen in IDLE makes m_axis_tvalid follow that port's tvalid from the next cycle.
REQ-019 In BUSY, m_axis_* SHALL be a combinational mux of the granted port.
REQ-020 In BUSY, granted sN_axis_tready SHALL equal m_axis_tready.
REQ-021 Non-granted tready SHALL be 0, and all tready SHALL be 0 in IDLE.
REQ-022 In IDLE, m_axis_tvalid, tlast and tuser SHALL be 0, and tdata and tkeep SHALL be 0.
REQ-023 A frame SHALL be atomic: the grant is held until a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast.
REQ-024 On the atomic-frame handshake (REQ-023), the FSM SHALL return to IDLE and o_frm_cnt[grant] SHALL increment, wrapping 16'hFFFF to 0.
REQ-025 A minimum one-cycle IDLE gap SHALL separate consecutive frames, including back-to-back frames from the same port.
REQ-026 i_slot_guard SHALL only block new grants; a frame already in flight completes normally.
REQ-027 A 16-bit stall counter SHALL clear on grant and on every handshake beat, and SHALL increment on every other BUSY cycle.
REQ-028 When the stall counter reaches P_TIMEOUT, the FSM SHALL go to IDLE and pulse o_abort for 1 cycle, with no frame-count increment.
REQ-029 If a tlast handshake and the timeout occur in the same cycle, the handshake SHALL win: normal completion, no abort.
REQ-030 A requester whose tvalid drops mid-frame SHALL keep the grant; this case is governed by the stall counter.
REQ-031 o_busy SHALL be 1 exactly in BUSY.

Reset
REQ-032 While i_rst_n=0, the state SHALL be IDLE, o_grant=2'd3, o_busy=0, o_abort=0, all counters 0, the stall counter 0, and the rr pointer favouring s1.
REQ-033 While i_rst_n=0, all tready and m_axis_* SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL drop the frame immediately, with no count increment.
REQ-035 After reset release, the first grant SHALL be possible on the first edge.
REQ-036 All registers SHALL use the asynchronous active-low reset; there SHALL be no synchronous reset term.

Verification
REQ-037 Single frame: s1 sends 8 beats, m_axis_tready=1 -> o_grant=1 one cycle after tvalid; 8 beats pass unchanged; o_frm_cnt1=1; IDLE after the last beat.
REQ-038 Simultaneous request: s0, s1 and s2 all request together -> order s0, s1, s0?; with s0 requesting only once, the order is s0, s1, s2, each separated by 1 IDLE cycle.
REQ-039 Slot guard: i_slot_guard raised during beat 3 of an s2 frame -> the frame completes; s1 waits until guard=0, then is granted one cycle later.
REQ-040 Timeout: with P_TIMEOUT=10, s1 stops after beat 2 with no tlast -> o_abort pulses 10 stall cycles later, o_frm_cnt1 is unchanged, and the FSM is in IDLE.
REQ-041 Timeout collision: tlast handshake in the same cycle the stall count hits P_TIMEOUT -> no abort, count increments.
REQ-042 Reset mid-frame: i_rst_n pulsed low during beat 4 -> all outputs are 0 immediately; after release, a pending s0 request is granted next edge.

Source files
------------

// File: rtl/ocs_tx_arb.sv
// ocs_tx_arb: three-requester AXI-Stream TX arbiter in front of the MAC.
// s0 (time-sync) has absolute priority; s1 (slot-control) and s2 (data)
// share a one-bit round-robin pointer. Frames are atomic, consecutive
// frames are separated by at least one idle cycle, and a granted frame
// that stalls too long is aborted.
module ocs_tx_arb #(
  parameter logic [15:0] P_TIMEOUT = 16'd300,
  parameter int          P_DATA_W  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // requester 0: time-sync frames
  input  logic                  s0_axis_tvalid,
  input  logic [P_DATA_W-1:0]   s0_axis_tdata,
  input  logic                  s0_axis_tlast,
  input  logic [P_DATA_W/8-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tuser,
  output logic                  s0_axis_tready,
  // requester 1: slot-control frames
  input  logic                  s1_axis_tvalid,
  input  logic [P_DATA_W-1:0]   s1_axis_tdata,
  input  logic                  s1_axis_tlast,
  input  logic [P_DATA_W/8-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tuser,
  output logic                  s1_axis_tready,
  // requester 2: data frames
  input  logic                  s2_axis_tvalid,
  input  logic [P_DATA_W-1:0]   s2_axis_tdata,
  input  logic                  s2_axis_tlast,
  input  logic [P_DATA_W/8-1:0] s2_axis_tkeep,
  input  logic                  s2_axis_tuser,
  output logic                  s2_axis_tready,
  // shared TX port toward the MAC
  output logic                  m_axis_tvalid,
  output logic [P_DATA_W-1:0]   m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [P_DATA_W/8-1:0] m_axis_tkeep,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  // control and status
  input  logic                  i_slot_guard,
  output logic [1:0]            o_grant,
  output logic                  o_busy,
  output logic                  o_abort,
  output logic [15:0]           o_frm_cnt0,
  output logic [15:0]           o_frm_cnt1,
  output logic [15:0]           o_frm_cnt2
);

  localparam int          KEEP_W   = P_DATA_W / 8;
  localparam logic [1:0]  GNT_NONE = 2'd3;
  // The stall counter reaches P_TIMEOUT on the same edge that leaves BUSY,
  // so the abort decision is taken while it still holds P_TIMEOUT-1.
  localparam logic [15:0] TO_LAST  = P_TIMEOUT - 16'd1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [1:0]  grant;
  logic        rr_s2;       // 0: s1 wins a tie with s2, 1: s2 wins
  logic [15:0] stall_cnt;
  logic [1:0]  arb_sel;
  logic        arb_go;
  logic        hs;
  logic        done;
  logic        timeout;

  // Priority pick among the current requests (only consumed in IDLE)
  always_comb begin
    arb_sel = GNT_NONE;
    if (s0_axis_tvalid)                       arb_sel = 2'd0;
    else if (s1_axis_tvalid && s2_axis_tvalid) arb_sel = rr_s2 ? 2'd2 : 2'd1;
    else if (s1_axis_tvalid)                  arb_sel = 2'd1;
    else if (s2_axis_tvalid)                  arb_sel = 2'd2;
  end

  assign arb_go  = (state == IDLE) && !i_slot_guard &&
                   (s0_axis_tvalid || s1_axis_tvalid || s2_axis_tvalid);
  assign hs      = m_axis_tvalid && m_axis_tready;
  assign done    = hs && m_axis_tlast;
  // A handshake in the deciding cycle keeps the frame alive (and a tlast
  // handshake completes it normally), so it always beats the timeout.
  assign timeout = (state == BUSY) && !hs && (stall_cnt == TO_LAST);

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic; always returning to IDLE enforces the inter-frame gap
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_go)          state_nxt = BUSY;
      BUSY:    if (done || timeout) state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // FSM outputs: combinational mux of the granted port, all-zero when idle
  always_comb begin
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tkeep   = {KEEP_W{1'b0}};
    m_axis_tuser   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    s2_axis_tready = 1'b0;
    if (state == BUSY) begin
      case (grant)
        2'd0: begin
          m_axis_tvalid  = s0_axis_tvalid;
          m_axis_tdata   = s0_axis_tdata;
          m_axis_tlast   = s0_axis_tlast;
          m_axis_tkeep   = s0_axis_tkeep;
          m_axis_tuser   = s0_axis_tuser;
          s0_axis_tready = m_axis_tready;
        end
        2'd1: begin
          m_axis_tvalid  = s1_axis_tvalid;
          m_axis_tdata   = s1_axis_tdata;
          m_axis_tlast   = s1_axis_tlast;
          m_axis_tkeep   = s1_axis_tkeep;
          m_axis_tuser   = s1_axis_tuser;
          s1_axis_tready = m_axis_tready;
        end
        2'd2: begin
          m_axis_tvalid  = s2_axis_tvalid;
          m_axis_tdata   = s2_axis_tdata;
          m_axis_tlast   = s2_axis_tlast;
          m_axis_tkeep   = s2_axis_tkeep;
          m_axis_tuser   = s2_axis_tuser;
          s2_axis_tready = m_axis_tready;
        end
        default: ;
      endcase
    end
  end

  // Grant register: latched on arbitration, parked at 3 whenever idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                grant <= GNT_NONE;
    else if (arb_go)                             grant <= arb_sel;
    else if ((state == BUSY) && (done || timeout)) grant <= GNT_NONE;
  end

  // Round-robin pointer: moves away from whichever of s1/s2 was just granted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                         rr_s2 <= 1'b0;
    else if (arb_go && (arb_sel == 2'd1)) rr_s2 <= 1'b1;
    else if (arb_go && (arb_sel == 2'd2)) rr_s2 <= 1'b0;
  end

  // Stall counter: cleared on grant and on every beat, counts idle BUSY cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            stall_cnt <= '0;
    else if (arb_go)         stall_cnt <= '0;
    else if (state == BUSY)  stall_cnt <= hs ? 16'd0 : stall_cnt + 16'd1;
  end

  // Abort pulse, one cycle, in the first idle cycle after a timeout
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_abort <= 1'b0;
    else          o_abort <= timeout;
  end

  // Completed-frame counters, one per requester, free-running wrap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frm_cnt0 <= '0;
      o_frm_cnt1 <= '0;
      o_frm_cnt2 <= '0;
    end else if ((state == BUSY) && done) begin
      case (grant)
        2'd0:    o_frm_cnt0 <= o_frm_cnt0 + 16'd1;
        2'd1:    o_frm_cnt1 <= o_frm_cnt1 + 16'd1;
        2'd2:    o_frm_cnt2 <= o_frm_cnt2 + 16'd1;
        default: ;
      endcase
    end
  end

  assign o_grant = grant;
  assign o_busy  = (state == BUSY);

endmodule

// File: tb/tb_ocs_tx_arb.sv
// tb_ocs_tx_arb: directed bench for ocs_tx_arb with hand-computed expectations.
module tb_ocs_tx_arb;

  logic        i_clk, i_rst_n;
  logic        s0_tvalid, s0_tlast, s0_tuser, s0_tready;
  logic [63:0] s0_tdata;
  logic [7:0]  s0_tkeep;
  logic        s1_tvalid, s1_tlast, s1_tuser, s1_tready;
  logic [63:0] s1_tdata;
  logic [7:0]  s1_tkeep;
  logic        s2_tvalid, s2_tlast, s2_tuser, s2_tready;
  logic [63:0] s2_tdata;
  logic [7:0]  s2_tkeep;
  logic        m_tvalid, m_tlast, m_tuser, m_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        slot_guard, busy, abort;
  logic [1:0]  grant;
  logic [15:0] cnt0, cnt1, cnt2;

  int n_chk = 0;
  int n_err = 0;

  ocs_tx_arb #(.P_TIMEOUT(16'd10), .P_DATA_W(64)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .s0_axis_tvalid (s0_tvalid), .s0_axis_tdata(s0_tdata), .s0_axis_tlast(s0_tlast),
    .s0_axis_tkeep  (s0_tkeep),  .s0_axis_tuser(s0_tuser), .s0_axis_tready(s0_tready),
    .s1_axis_tvalid (s1_tvalid), .s1_axis_tdata(s1_tdata), .s1_axis_tlast(s1_tlast),
    .s1_axis_tkeep  (s1_tkeep),  .s1_axis_tuser(s1_tuser), .s1_axis_tready(s1_tready),
    .s2_axis_tvalid (s2_tvalid), .s2_axis_tdata(s2_tdata), .s2_axis_tlast(s2_tlast),
    .s2_axis_tkeep  (s2_tkeep),  .s2_axis_tuser(s2_tuser), .s2_axis_tready(s2_tready),
    .m_axis_tvalid  (m_tvalid),  .m_axis_tdata(m_tdata),   .m_axis_tlast(m_tlast),
    .m_axis_tkeep   (m_tkeep),   .m_axis_tuser(m_tuser),   .m_axis_tready(m_tready),
    .i_slot_guard   (slot_guard),
    .o_grant        (grant),
    .o_busy         (busy),
    .o_abort        (abort),
    .o_frm_cnt0     (cnt0),
    .o_frm_cnt1     (cnt1),
    .o_frm_cnt2     (cnt2)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here
  task automatic cyc();
    @(posedge i_clk);
    #2;
  endtask

  task automatic drv(input int p, input logic v, input logic [63:0] d, input logic l);
    case (p)
      0: begin s0_tvalid = v; s0_tdata = d; s0_tlast = l; s0_tkeep = 8'hFF; s0_tuser = d[0]; end
      1: begin s1_tvalid = v; s1_tdata = d; s1_tlast = l; s1_tkeep = 8'hFF; s1_tuser = d[0]; end
      default: begin s2_tvalid = v; s2_tdata = d; s2_tlast = l; s2_tkeep = 8'hFF; s2_tuser = d[0]; end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst_n = 1'b0;
    slot_guard = 1'b0;
    m_tready = 1'b1;
    drv(0, 1'b1, 64'h1234, 1'b1);
    drv(1, 1'b0, 64'h0, 1'b0);
    drv(2, 1'b0, 64'h0, 1'b0);

    // ---- reset state, with a request already present ----
    repeat (2) @(posedge i_clk);
    #3;
    chk("rst_grant",  grant,     2'd3);
    chk("rst_busy",   busy,      1'b0);
    chk("rst_abort",  abort,     1'b0);
    chk("rst_cnt0",   cnt0,      16'd0);
    chk("rst_cnt1",   cnt1,      16'd0);
    chk("rst_cnt2",   cnt2,      16'd0);
    chk("rst_mvalid", m_tvalid,  1'b0);
    chk("rst_mdata",  m_tdata,   64'h0);
    chk("rst_rdy0",   s0_tready, 1'b0);

    // ---- simultaneous request: s0, s1, s2 (single-beat frames) ----
    drv(0, 1'b1, 64'hD0, 1'b1);
    drv(1, 1'b1, 64'hD1, 1'b1);
    drv(2, 1'b1, 64'hD2, 1'b1);
    i_rst_n = 1'b1;
    #1;
    chk("sim_idle_grant", grant, 2'd3);
    cyc(); #1;
    chk("sim_g0",      grant,     2'd0);
    chk("sim_g0_data", m_tdata,   64'hD0);
    chk("sim_g0_rdy0", s0_tready, 1'b1);
    chk("sim_g0_rdy1", s1_tready, 1'b0);
    chk("sim_g0_last", m_tlast,   1'b1);
    cyc(); drv(0, 1'b0, 64'h0, 1'b0); #1;
    chk("sim_gap1_grant", grant,    2'd3);
    chk("sim_gap1_busy",  busy,     1'b0);
    chk("sim_gap1_mdata", m_tdata,  64'h0);
    chk("sim_gap1_rdy1",  s1_tready, 1'b0);
    cyc(); #1;
    chk("sim_g1",      grant,   2'd1);
    chk("sim_g1_data", m_tdata, 64'hD1);
    cyc(); drv(1, 1'b0, 64'h0, 1'b0); #1;
    chk("sim_gap2_grant", grant, 2'd3);
    cyc(); #1;
    chk("sim_g2",      grant,     2'd2);
    chk("sim_g2_data", m_tdata,   64'hD2);
    chk("sim_g2_rdy2", s2_tready, 1'b1);
    cyc(); drv(2, 1'b0, 64'h0, 1'b0); #1;
    chk("sim_end_grant", grant, 2'd3);
    chk("sim_cnt0", cnt0, 16'd1);
    chk("sim_cnt1", cnt1, 16'd1);
    chk("sim_cnt2", cnt2, 16'd1);

    // ---- single 8-beat frame from s1 ----
    drv(1, 1'b1, 64'hA000, 1'b0);
    #1;
    chk("one_pre_grant", grant,     2'd3);
    chk("one_pre_rdy1",  s1_tready, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      drv(1, 1'b1, 64'hA000 + 64'(i), (i == 7));
      #1;
      chk("one_grant", grant,   2'd1);
      chk("one_data",  m_tdata, 64'hA000 + 64'(i));
      chk("one_last",  m_tlast, (i == 7));
      chk("one_user",  m_tuser, i[0]);
    end
    chk("one_keep", m_tkeep, 8'hFF);
    cyc(); drv(1, 1'b0, 64'h0, 1'b0); #1;
    chk("one_end_busy",  busy,  1'b0);
    chk("one_end_grant", grant, 2'd3);
    chk("one_cnt1",      cnt1,  16'd2);

    // ---- slot guard raised during beat 3 of a 5-beat s2 frame ----
    drv(2, 1'b1, 64'hB000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      drv(2, 1'b1, 64'hB000 + 64'(i), (i == 4));
      if (i == 3) begin
        slot_guard = 1'b1;
        drv(1, 1'b1, 64'hC000, 1'b1);
      end
      #1;
      chk("grd_grant", grant,   2'd2);
      chk("grd_data",  m_tdata, 64'hB000 + 64'(i));
      if (i >= 3) chk("grd_rdy1", s1_tready, 1'b0);
    end
    cyc(); drv(2, 1'b0, 64'h0, 1'b0); #1;
    chk("grd_done_grant", grant, 2'd3);
    chk("grd_cnt2",       cnt2,  16'd2);
    cyc(); #1;
    chk("grd_hold_grant", grant, 2'd3);
    slot_guard = 1'b0;
    cyc(); #1;
    chk("grd_g1",      grant,   2'd1);
    chk("grd_g1_data", m_tdata, 64'hC000);
    cyc(); drv(1, 1'b0, 64'h0, 1'b0); #1;
    chk("grd_cnt1", cnt1, 16'd3);

    // ---- timeout: s1 stops after beat 2, P_TIMEOUT = 10 ----
    drv(1, 1'b1, 64'hD100, 1'b0);
    cyc(); #1;
    chk("to_b0_grant", grant, 2'd1);
    cyc(); drv(1, 1'b1, 64'hD101, 1'b0); #1;
    chk("to_b1_data", m_tdata, 64'hD101);
    cyc(); drv(1, 1'b0, 64'h0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk("to_stall_busy",  busy,  1'b1);
      chk("to_stall_abort", abort, 1'b0);
      cyc();
    end
    #1;
    chk("to_abort",      abort, 1'b1);
    chk("to_busy",       busy,  1'b0);
    chk("to_grant",      grant, 2'd3);
    chk("to_cnt1",       cnt1,  16'd3);
    cyc(); #1;
    chk("to_abort_fall", abort, 1'b0);

    // ---- collision: tlast handshake in the deciding cycle ----
    drv(1, 1'b1, 64'hE000, 1'b0);
    cyc(); #1;
    chk("col_b0_grant", grant, 2'd1);
    cyc(); drv(1, 1'b0, 64'h0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      #1;
      chk("col_stall_busy", busy, 1'b1);
      cyc();
    end
    drv(1, 1'b1, 64'hE001, 1'b1);
    #1;
    chk("col_last_busy", busy,      1'b1);
    chk("col_last_rdy1", s1_tready, 1'b1);
    cyc(); drv(1, 1'b0, 64'h0, 1'b0); #1;
    chk("col_abort", abort, 1'b0);
    chk("col_busy",  busy,  1'b0);
    chk("col_cnt1",  cnt1,  16'd4);

    // ---- reset asserted during beat 4 of an s2 frame ----
    drv(2, 1'b1, 64'hF000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      drv(2, 1'b1, 64'hF000 + 64'(i), 1'b0);
      #1;
      chk("rm_grant", grant, 2'd2);
    end
    drv(0, 1'b1, 64'h5A5A, 1'b1);
    i_rst_n = 1'b0;
    #1;
    chk("rm_mvalid", m_tvalid,  1'b0);
    chk("rm_mdata",  m_tdata,   64'h0);
    chk("rm_grant0", grant,     2'd3);
    chk("rm_busy",   busy,      1'b0);
    chk("rm_rdy2",   s2_tready, 1'b0);
    chk("rm_rdy0",   s0_tready, 1'b0);
    chk("rm_cnt1",   cnt1,      16'd0);
    drv(2, 1'b0, 64'h0, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc(); #1;
    chk("rm_post_grant", grant,   2'd0);
    chk("rm_post_data",  m_tdata, 64'h5A5A);
    cyc(); drv(0, 1'b0, 64'h0, 1'b0); #1;
    chk("rm_post_idle", grant, 2'd3);
    chk("rm_post_cnt0", cnt0,  16'd1);
    chk("rm_post_cnt2", cnt2,  16'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
